seq_d: RTL and testbench

SEQ_D -- requirements
Module: seq_d

---
 rtl/seq_d_pkg.sv | 15 +
 rtl/seq_d_dff.sv | 14 +
 rtl/seq_d.sv | 36 +++
 tb/tb_seq_d.sv | 119 +++++++++++
 4 files changed

// File: rtl/seq_d_pkg.sv
// Shared state codes and pattern constants for the 1010 sequence detector.
package seq_d_pkg;

   typedef enum logic [2:0] {
      S0 = 3'b000,
      S1 = 3'b001,
      S2 = 3'b010,
      S3 = 3'b011,
      S4 = 3'b100
   } state_t;

   localparam int unsigned PATTERN_W = 4;
   localparam logic [PATTERN_W-1:0] PATTERN = 4'b1010;

endpackage

// File: rtl/seq_d_dff.sv
// 1-bit D flip-flop with synchronous active-low reset.
module dff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk) begin
      if (!reset) q <= 1'b0;
      else        q <= d;
   end

endmodule

// File: rtl/seq_d.sv
// Moore detector for overlapping 1010; state lives in three dff bits, y decoded from state only.
module seq_d
   import seq_d_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic x,
   output logic y
);

   logic       q0, q1, q2;
   logic [2:0] state;
   logic [2:0] nxt;

   assign state = {q2, q1, q0};

   dff u_ff0 (.clk(clk), .reset(reset), .d(nxt[0]), .q(q0));
   dff u_ff1 (.clk(clk), .reset(reset), .d(nxt[1]), .q(q1));
   dff u_ff2 (.clk(clk), .reset(reset), .d(nxt[2]), .q(q2));

   // Unused codes fall through to the default and recover to S0.
   always_comb begin
      nxt = S0;
      case (state)
         S0:      nxt = x ? S1 : S0;
         S1:      nxt = x ? S1 : S2;
         S2:      nxt = x ? S3 : S0;
         S3:      nxt = x ? S1 : S4;
         S4:      nxt = x ? S3 : S0;
         default: nxt = S0;
      endcase
   end

   assign y = (state == S4);

endmodule

// File: tb/tb_seq_d.sv
// Directed table-driven bench for seq_d plus forced illegal-state recovery.
module tb_seq_d;
   import seq_d_pkg::*;

   logic clk;
   logic reset;
   logic x;
   logic y;

   int unsigned checks = 0;
   int unsigned errors = 0;

   typedef struct {
      logic       rst;
      logic       x;
      logic [2:0] st;
      logic       y;
      string      name;
   } vec_t;

   vec_t tbl[$];

   seq_d dut (.clk(clk), .reset(reset), .x(x), .y(y));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(input logic r, input logic xv, input logic [2:0] s,
                               input logic yv, input string n);
      vec_t v;
      v.rst = r; v.x = xv; v.st = s; v.y = yv; v.name = n;
      tbl.push_back(v);
   endfunction

   task automatic check_st(input string n, input logic [2:0] exp_st, input logic exp_y);
      checks++;
      if (dut.state !== exp_st || y !== exp_y) begin
         errors++;
         $display("FAIL %s: state=%b y=%b, required state=%b y=%b",
                  n, dut.state, y, exp_st, exp_y);
      end
   endtask

   initial begin
      logic [PATTERN_W-1:0] pat;
      logic [2:0]           bad;
      reset = 1'b0;
      x     = 1'b0;
      pat   = PATTERN;

      add(0, 0, S0, 0, "reset");
      // Overlap stream
      add(1, 0, S0, 0, "ovl0"); add(1, 1, S1, 0, "ovl1");
      add(1, 1, S1, 0, "ovl2"); add(1, 0, S2, 0, "ovl3");
      add(1, 1, S3, 0, "ovl4"); add(1, 0, S4, 1, "ovl5");
      add(1, 1, S3, 0, "ovl6"); add(1, 0, S4, 1, "ovl7");
      // Non-match stream
      add(0, 0, S0, 0, "nm_rst");
      add(1, 1, S1, 0, "nm0"); add(1, 1, S1, 0, "nm1");
      add(1, 1, S1, 0, "nm2"); add(1, 0, S2, 0, "nm3");
      add(1, 0, S0, 0, "nm4"); add(1, 1, S1, 0, "nm5");
      add(1, 1, S1, 0, "nm6"); add(1, 0, S2, 0, "nm7");
      // Mid-sequence reset
      add(0, 0, S0, 0, "mid_rst0");
      add(1, 1, S1, 0, "mid0"); add(1, 0, S2, 0, "mid1");
      add(1, 1, S3, 0, "mid2"); add(0, 0, S0, 0, "mid_rst");
      add(1, 0, S0, 0, "mid_idle");
      add(1, 1, S1, 0, "mid3"); add(1, 0, S2, 0, "mid4");
      add(1, 1, S3, 0, "mid5"); add(1, 0, S4, 1, "mid6");
      // Back-to-back built from the pattern constant, then S4 exit and reset from S4
      add(0, 0, S0, 0, "b2b_rst");
      add(1, pat[3], S1, 0, "b2b0"); add(1, pat[2], S2, 0, "b2b1");
      add(1, pat[1], S3, 0, "b2b2"); add(1, pat[0], S4, 1, "b2b3");
      add(1, pat[1], S3, 0, "b2b4"); add(1, pat[0], S4, 1, "b2b5");
      add(1, 0, S0, 0, "s4_x0");
      add(1, 1, S1, 0, "re1"); add(1, 0, S2, 0, "re2");
      add(1, 1, S3, 0, "re3"); add(1, 0, S4, 1, "re4");
      add(0, 1, S0, 0, "rst_from_s4");

      foreach (tbl[i]) begin
         @(negedge clk);
         reset = tbl[i].rst;
         x     = tbl[i].x;
         @(posedge clk);
         #1;
         check_st(tbl[i].name, tbl[i].st, tbl[i].y);
      end

      // Illegal codes: y must be low while held, and one edge returns to S0 even with x=1.
      for (int unsigned c = 5; c <= 7; c++) begin
         bad = c[2:0];
         @(negedge clk);
         reset = 1'b1;
         x     = 1'b1;
         force dut.state = bad;
         #1;
         checks++;
         if (y !== 1'b0) begin
            errors++;
            $display("FAIL illegal_y_%0d: y=%b, required 0", c, y);
         end
         @(posedge clk);
         #1;
         release dut.state;
         #1;
         check_st($sformatf("illegal_rec_%0d", c), S0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, required finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
